// File: rtl/spi_mstr16.sv
// 16-bit SPI master, mode 3 (SCLK idles high, MOSI launched on SCLK fall,
// MISO sampled on SCLK rise). SCLK = clk/32, fixed 16-bit frames.
module spi_mstr16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrt,
  input  logic [15:0] cmd,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  typedef enum logic [1:0] {IDLE, FRONT, SHIFT, BACK} state_t;

  state_t      state, nxt_state;
  logic [4:0]  div;
  logic [15:0] shft;
  logic        smpl;
  logic [3:0]  bit_cnt;

  logic        load;
  logic        sample;
  logic        shift;
  logic        finish;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt_state;
  end

  // Next-state and datapath control decode
  always_comb begin
    nxt_state = state;
    load      = 1'b0;
    sample    = 1'b0;
    shift     = 1'b0;
    finish    = 1'b0;
    unique case (state)
      IDLE: begin
        if (wrt) begin
          load      = 1'b1;
          nxt_state = FRONT;
        end
      end
      FRONT: begin
        // First SCLK fall happens on this transition but shifts nothing:
        // MOSI already presents cmd[15] since the load.
        if (div == 5'h1F) nxt_state = SHIFT;
      end
      SHIFT: begin
        if (div == 5'h0F) begin
          sample = 1'b1;
          if (bit_cnt == 4'hF) nxt_state = BACK;
        end else if (div == 5'h1F) begin
          shift = 1'b1;
        end
      end
      BACK: begin
        if (div == 5'h1F) begin
          shift     = 1'b1;
          finish    = 1'b1;
          nxt_state = IDLE;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // SCLK divider: parked at all-ones when idle so SCLK stays high
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          div <= 5'h1F;
    else if (load)                    div <= 5'b10111;
    else if (state == IDLE || finish) div <= 5'h1F;
    else                              div <= div + 5'd1;
  end

  // Shift register: transmit word out of the MSB, received bits into the LSB
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        shft <= '0;
    else if (load)  shft <= cmd;
    else if (shift) shft <= {shft[14:0], smpl};
  end

  // MISO sample flop, loaded on SCLK rise
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         smpl <= 1'b0;
    else if (sample) smpl <= MISO;
  end

  // Count of completed shifts, used to detect the 16th sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        bit_cnt <= '0;
    else if (load)  bit_cnt <= '0;
    else if (shift) bit_cnt <= bit_cnt + 4'd1;
  end

  // done: set on frame completion, cleared when the next frame is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         done <= 1'b0;
    else if (load)   done <= 1'b0;
    else if (finish) done <= 1'b1;
  end

  assign SS_n    = (state == IDLE);
  assign SCLK    = div[4];
  assign MOSI    = shft[15];
  assign rd_data = shft;

endmodule

// File: doc/spi_mstr16.md
Name: spi_mstr16

Overview:
- 16-bit SPI master (mode 3: SCLK idles high, MOSI launched on falling edge, MISO sampled on rising edge).
- Sits directly upstream of the inertial interface, which issues sensor register reads and writes (calibration writes, then pitch/roll/yaw data reads) through it.
- The inertial interface sees only a wrt/cmd/done/rd_data handshake; this block owns the SS_n/SCLK/MOSI/MISO pins toward the inertial sensor.

Parameters:
- None.
- SCLK is fixed at clk/32.
- Frame length is fixed at 16 bits.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- wrt  input  1  start a transaction (1-clk pulse or level; sampled only in IDLE)
- cmd  input  16  word to transmit MSB-first; captured on the clk edge that accepts wrt
- done  output  1  transaction complete; held high until next accepted wrt
- rd_data  output  16  word received MSB-first; valid while done=1
- SS_n  output  1  active-low slave select
- SCLK  output  1  serial clock
- MOSI  output  1  serial data out
- MISO  input  1  serial data in

Behaviour:
- Interface: one clock (clk); reset asynchronous and active-high (rst).
- Reset values (async, immediate): state=IDLE, SS_n=1, SCLK=1, done=0, shift register=16'h0000 (so MOSI=0, rd_data=0), divider=5'b11111.
- Datapath:
  - 5-bit divider div; SCLK = div[4].
  - 16-bit shift register shft; MOSI = shft[15]; rd_data = shft.
  - 1-bit sample flop smpl.
- States: IDLE, FRONT, SHIFT, BACK. SS_n = (state==IDLE).
- IDLE:
  - div held at 11111.
  - On wrt: load shft<=cmd, div<=5'b10111, done<=0, go to FRONT.
  - Edge numbering: call this accepting edge t0. Edge t0+k is the k-th clk edge after t0.
- FRONT (front porch):
  - div increments each clk.
  - When div==11111: go to SHIFT; div wraps to 00000. This is the first SCLK fall, at t0+9, and it does NOT shift.
- SHIFT:
  - div increments each clk.
  - div==01111: smpl<=MISO (SCLK rises this edge).
  - div==11111: shft<={shft[14:0],smpl}; bit count increments.
  - On the 16th sample, go to BACK.
- BACK (back porch):
  - div increments until div==11111.
  - At that edge: final shift shft<={shft[14:0],smpl}, div held at 11111 (no SCLK fall), done<=1, state<=IDLE.
- Exact timing, edges relative to t0:
  - SS_n low from t0 to t0+521, i.e. 521 clks.
  - SCLK falls at t0+9 and every 32 clks after (16 falls).
  - SCLK rises at t0+25+32n, n=0..15 (16 rises; last at t0+505).
  - done rises at t0+521.
  - SCLK is high whenever SS_n is high.
- wrt while not IDLE: ignored. No effect on cmd capture, timing, or done.
- wrt in IDLE while done=1: accepted; done clears on the accepting edge. This gives back-to-back frames with one idle cycle minimum.
- rst mid-transaction: immediate abort to reset values. No done pulse. Next wrt starts a clean frame.
- MISO is sampled directly, with no synchronizer; the sensor is clocked by SCLK from this block.

Test Plan:
- Reset: assert rst with no clk edges -> SS_n=1, SCLK=1, done=0, rd_data=16'h0000, MOSI=0 immediately. Deassert, hold wrt=0 for 100 clks -> outputs unchanged.
- Single frame: wrt pulse with cmd=16'h8F00; sensor model drives 16'h6A5C, MSB changing on SCLK fall.
  - MOSI captured at the 16 SCLK rises = 1000_1111_0000_0000.
  - done rises exactly 521 clks after the accepting edge.
  - rd_data=16'h6A5C.
- SCLK/SS_n framing: count edges over one frame -> exactly 16 rising and 16 falling SCLK edges, all while SS_n=0. First fall 9 clks after SS_n falls; no SCLK fall at or after SS_n rise.
- Busy wrt: issue second wrt pulses (cmd=16'hFFFF) at t0+100 and t0+400 -> frame identical to the single-frame case. rd_data correct, one done rise only.
- Reset mid-frame: assert rst at t0+250 (mid bit 7) -> SS_n=1, SCLK=1, done=0 immediately. A new wrt with cmd=16'h0D60 after release completes normally with correct rd_data.
- Back-to-back: wrt asserted in the first cycle done=1 (cmd=16'hA5A5, then 16'h0202) -> done drops on the accepting edge. Second frame is again 521 clks with correct MOSI. Both rd_data values match the model.
